muldiv_unit: RTL

Iterative multiply/divide unit implementing the RV32M/RV64M operations for the execute stage, alongside the single-cycle ALU. Parametrised in XLEN. One operation is in flight at a time, with valid/ready handshakes on both the request and result sides. Multiplication uses radix-2 shift-add and division uses restoring division, each taking XLEN iterations. Divide-by-zero and signed overflow are short-circuited.

---
 rtl/muldiv_package.sv | 53 +++++
 rtl/muldiv_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_package.sv
// Shared definitions for the iterative multiply/divide unit.
//   - MULDIV_OPCODE_*  : M-extension funct3 encodings
//   - muldiv_state_t   : control FSM states
//   - is_divide / is_signed_operand1 / is_signed_operand2 : opcode predicates
package muldiv_package;

    localparam logic [2:0] MULDIV_OPCODE_MUL    = 3'b000;
    localparam logic [2:0] MULDIV_OPCODE_MULH   = 3'b001;
    localparam logic [2:0] MULDIV_OPCODE_MULHSU = 3'b010;
    localparam logic [2:0] MULDIV_OPCODE_MULHU  = 3'b011;
    localparam logic [2:0] MULDIV_OPCODE_DIV    = 3'b100;
    localparam logic [2:0] MULDIV_OPCODE_DIVU   = 3'b101;
    localparam logic [2:0] MULDIV_OPCODE_REM    = 3'b110;
    localparam logic [2:0] MULDIV_OPCODE_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MULDIV_STATE_IDLE    = 2'd0,
        MULDIV_STATE_COMPUTE = 2'd1,
        MULDIV_STATE_FINISH  = 2'd2,
        MULDIV_STATE_DONE    = 2'd3
    } muldiv_state_t;

    // All divide/remainder opcodes have funct3[2] set.
    function automatic logic is_divide(input logic [2:0] op);
        return op[2];
    endfunction

    // operand1 is read as signed for MULH, MULHSU, DIV and REM.
    function automatic logic is_signed_operand1(input logic [2:0] op);
        logic r;
        case (op)
            MULDIV_OPCODE_MULH:   r = 1'b1;
            MULDIV_OPCODE_MULHSU: r = 1'b1;
            MULDIV_OPCODE_DIV:    r = 1'b1;
            MULDIV_OPCODE_REM:    r = 1'b1;
            default:              r = 1'b0;
        endcase
        return r;
    endfunction

    // operand2 is read as signed for MULH, DIV and REM.
    function automatic logic is_signed_operand2(input logic [2:0] op);
        logic r;
        case (op)
            MULDIV_OPCODE_MULH: r = 1'b1;
            MULDIV_OPCODE_DIV:  r = 1'b1;
            MULDIV_OPCODE_REM:  r = 1'b1;
            default:            r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit (radix-2 shift-add multiply,
// restoring divide, XLEN iterations each). One operation in flight.
// Ports:
//   clock, reset_n (synchronous, active low)
//   valid_in / ready_out          : request handshake (ready only in IDLE)
//   operation, operand1, operand2 : funct3 and rs1/rs2 values
//   result_valid / result_ready   : result handshake
//   result                        : registered result, stable while valid
module muldiv_unit
    import muldiv_package::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            valid_in,
    output logic            ready_out,
    input  logic [2:0]      operation,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    input  logic            result_ready
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t     r_state;
    muldiv_state_t     w_next_state;
    logic [2:0]        r_op;
    logic              r_sign1;
    logic              r_sign2;
    logic [XLEN-1:0]   r_operand;   // multiplicand (mul) or divisor (div), magnitude
    logic [2*XLEN-1:0] r_acc;       // {hi: product hi / remainder, lo: multiplier / dividend->quotient}
    logic [CW-1:0]     r_count;
    logic              r_ready;
    logic              r_result_valid;
    logic [XLEN-1:0]   r_result;

    logic              w_accept;
    logic              w_release;
    logic              w_last;
    logic              w_sign1;
    logic              w_sign2;
    logic [XLEN-1:0]   w_abs1;
    logic [XLEN-1:0]   w_abs2;
    logic              w_div_zero;
    logic              w_overflow;
    logic              w_special;
    logic [XLEN-1:0]   w_special_result;
    logic [XLEN:0]     w_add_a;
    logic [XLEN:0]     w_add_b;
    logic              w_add_cin;
    logic [XLEN+1:0]   w_add_sum;
    logic [2*XLEN-1:0] w_acc_next;
    logic [2*XLEN-1:0] w_fin_src;
    logic              w_fin_negate;
    logic [2*XLEN-1:0] w_fin_val;
    logic [XLEN-1:0]   w_fin_result;

    assign w_accept  = (r_state == MULDIV_STATE_IDLE) && r_ready && valid_in;
    assign w_release = (r_state == MULDIV_STATE_DONE) && r_result_valid && result_ready;
    assign w_last    = (r_count == CW'(XLEN - 1));

    assign w_sign1 = is_signed_operand1(operation) && operand1[XLEN-1];
    assign w_sign2 = is_signed_operand2(operation) && operand2[XLEN-1];
    assign w_abs1  = w_sign1 ? (~operand1 + XLEN'(1)) : operand1;
    assign w_abs2  = w_sign2 ? (~operand2 + XLEN'(1)) : operand2;

    assign w_div_zero = is_divide(operation) && (operand2 == {XLEN{1'b0}});
    assign w_overflow = ((operation == MULDIV_OPCODE_DIV) || (operation == MULDIV_OPCODE_REM))
                        && (operand1 == SIGNED_MIN) && (operand2 == {XLEN{1'b1}});
    assign w_special  = w_div_zero || w_overflow;

    // Short-circuit results: funct3[1] distinguishes REM* from DIV*.
    always_comb begin
        w_special_result = {XLEN{1'b0}};
        if (w_div_zero) begin
            w_special_result = operation[1] ? operand1 : {XLEN{1'b1}};
        end else begin
            w_special_result = operation[1] ? {XLEN{1'b0}} : operand1;
        end
    end

    // Shared adder operands: add multiplicand, or trial-subtract the divisor.
    always_comb begin
        w_add_a   = {(XLEN+1){1'b0}};
        w_add_b   = {(XLEN+1){1'b0}};
        w_add_cin = 1'b0;
        if (is_divide(r_op)) begin
            w_add_a   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
            w_add_b   = ~{1'b0, r_operand};
            w_add_cin = 1'b1;
        end else begin
            w_add_a   = {1'b0, r_acc[2*XLEN-1:XLEN]};
            w_add_b   = {1'b0, r_operand};
            w_add_cin = 1'b0;
        end
    end

    assign w_add_sum = {1'b0, w_add_a} + {1'b0, w_add_b} + {{(XLEN+1){1'b0}}, w_add_cin};

    // One iteration: carry-out of the subtract means "no borrow", i.e. quotient bit 1.
    always_comb begin
        w_acc_next = r_acc;
        if (is_divide(r_op)) begin
            if (w_add_sum[XLEN+1]) begin
                w_acc_next = {w_add_sum[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
            end else begin
                w_acc_next = {r_acc[2*XLEN-2:0], 1'b0};
            end
        end else begin
            if (r_acc[0]) begin
                w_acc_next = {w_add_sum[XLEN:0], r_acc[XLEN-1:1]};
            end else begin
                w_acc_next = {1'b0, r_acc[2*XLEN-1:1]};
            end
        end
    end

    // Sign fix-up: one negator serves the product and the selected quotient/remainder.
    always_comb begin
        w_fin_src    = r_acc;
        w_fin_negate = 1'b0;
        if (is_divide(r_op)) begin
            w_fin_src    = {{XLEN{1'b0}}, (r_op[1] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0])};
            w_fin_negate = r_op[1] ? r_sign1 : (r_sign1 ^ r_sign2);
        end else begin
            w_fin_src    = r_acc;
            w_fin_negate = r_sign1 ^ r_sign2;
        end
    end

    assign w_fin_val = w_fin_negate ? (~w_fin_src + (2*XLEN)'(1)) : w_fin_src;

    // Output select: MUL and all divides take the low half, MULH* the high half.
    always_comb begin
        w_fin_result = w_fin_val[XLEN-1:0];
        if (!is_divide(r_op) && (r_op != MULDIV_OPCODE_MUL)) begin
            w_fin_result = w_fin_val[2*XLEN-1:XLEN];
        end else begin
            w_fin_result = w_fin_val[XLEN-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= MULDIV_STATE_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MULDIV_STATE_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_special ? MULDIV_STATE_DONE : MULDIV_STATE_COMPUTE;
                end else begin
                    w_next_state = MULDIV_STATE_IDLE;
                end
            end
            MULDIV_STATE_COMPUTE: begin
                if (w_last) begin
                    w_next_state = MULDIV_STATE_FINISH;
                end else begin
                    w_next_state = MULDIV_STATE_COMPUTE;
                end
            end
            MULDIV_STATE_FINISH: w_next_state = MULDIV_STATE_DONE;
            MULDIV_STATE_DONE: begin
                if (w_release) begin
                    w_next_state = MULDIV_STATE_IDLE;
                end else begin
                    w_next_state = MULDIV_STATE_DONE;
                end
            end
            default: w_next_state = MULDIV_STATE_IDLE;
        endcase
    end

    // Datapath and registered handshake outputs. ready_out rises one cycle
    // after entering IDLE, so a release and the next accept never share an edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_op           <= 3'b000;
            r_sign1        <= 1'b0;
            r_sign2        <= 1'b0;
            r_operand      <= {XLEN{1'b0}};
            r_acc          <= {(2*XLEN){1'b0}};
            r_count        <= {CW{1'b0}};
            r_ready        <= 1'b1;
            r_result_valid <= 1'b0;
            r_result       <= {XLEN{1'b0}};
        end else begin
            r_ready        <= (r_state == MULDIV_STATE_IDLE) && !w_accept;
            r_result_valid <= (r_state == MULDIV_STATE_DONE) && !w_release;
            case (r_state)
                MULDIV_STATE_IDLE: begin
                    if (w_accept) begin
                        r_op      <= operation;
                        r_sign1   <= w_sign1;
                        r_sign2   <= w_sign2;
                        r_count   <= {CW{1'b0}};
                        r_operand <= is_divide(operation) ? w_abs2 : w_abs1;
                        r_acc     <= {{XLEN{1'b0}}, (is_divide(operation) ? w_abs1 : w_abs2)};
                        if (w_special) begin
                            r_result <= w_special_result;
                        end
                    end
                end
                MULDIV_STATE_COMPUTE: begin
                    r_acc   <= w_acc_next;
                    r_count <= r_count + CW'(1);
                end
                MULDIV_STATE_FINISH: begin
                    r_result <= w_fin_result;
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

    assign ready_out    = r_ready;
    assign result_valid = r_result_valid;
    assign result       = r_result;

endmodule
